// File: rtl/point_generator.sv
// point_generator: escape-time Mandelbrot engine for one pixel.
// Maps (x,y) to c, iterates z <- z^2 + c from z=0, reports escape count.
module point_generator #(
  parameter int HBP            = 32,
  parameter int HBI            = 32,
  parameter int max_iterations = 255
) (
  input  logic                CLK,
  input  logic                SYS_RESET_N,
  input  logic                start,
  input  logic signed [HBP:0] re_scale,
  input  logic signed [HBP:0] im_scale,
  input  logic [11:0]         x,
  input  logic [11:0]         y,
  input  logic signed [HBP:0] re_start,
  input  logic signed [HBP:0] im_start,
  output logic                done,
  output logic [HBI-1:0]      iteration
);

  localparam int W  = HBP + 1;
  localparam int F  = HBP - 3;
  localparam int IW = F + 8;
  localparam int PW = 2 * IW;
  localparam int MW = F + W;
  localparam logic signed [PW:0] FOUR = (PW+1)'(4) << (2 * F);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ITER
  } state_t;

  state_t state, state_nx;

  logic                 done_nx;
  logic [HBI-1:0]       iter_nx;
  logic [HBI-1:0]       n, n_nx, n_inc;
  logic signed [IW-1:0] zr, zi, cr, ci;
  logic signed [IW-1:0] zr_nx, zi_nx, cr_nx, ci_nx;
  logic signed [IW-1:0] zr_new, zi_new;

  // pixel to complex point mapping
  logic signed [MW-1:0] xw, yw, rsw, isw, xp, yp;
  logic [W-1:0]         cr_map, ci_map;

  assign xw     = MW'(x);
  assign yw     = MW'(y);
  assign rsw    = MW'(re_scale);
  assign isw    = MW'(im_scale);
  assign xp     = xw * rsw;
  assign yp     = yw * isw;
  assign cr_map = re_start + xp[F +: W];
  assign ci_map = im_start + yp[F +: W];

  // one iteration step, with headroom so nothing wraps
  logic signed [PW-1:0] zr_w, zi_w, rr, ii, ri, dre;
  logic signed [PW:0]   nr_w, ni_w, mag;
  logic                 esc;

  assign zr_w   = PW'(zr);
  assign zi_w   = PW'(zi);
  assign rr     = zr_w * zr_w;
  assign ii     = zi_w * zi_w;
  assign ri     = zr_w * zi_w;
  assign dre    = rr - ii;
  assign zr_new = dre[F +: IW] + cr;
  assign zi_new = ri[F-1 +: IW] + ci;
  assign nr_w   = (PW+1)'(zr_new);
  assign ni_w   = (PW+1)'(zi_new);
  assign mag    = nr_w * nr_w + ni_w * ni_w;
  assign n_inc  = n + HBI'(1);
  assign esc    = (mag > FOUR) || (n_inc == HBI'(max_iterations));

  logic unused_bits;
  assign unused_bits = ^{xp[F-1:0], yp[F-1:0],
                         dre[F-1:0], dre[PW-1:F+IW],
                         ri[F-2:0], ri[PW-1:F+IW-1]};

  // next state, datapath updates and result capture
  always_comb begin
    state_nx = state;
    done_nx  = done;
    iter_nx  = iteration;
    n_nx     = n;
    zr_nx    = zr;
    zi_nx    = zi;
    cr_nx    = cr;
    ci_nx    = ci;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = SETUP;
          done_nx  = 1'b0;
        end
      end
      SETUP: begin
        cr_nx    = IW'($signed(cr_map));
        ci_nx    = IW'($signed(ci_map));
        zr_nx    = '0;
        zi_nx    = '0;
        n_nx     = '0;
        state_nx = ITER;
      end
      ITER: begin
        if (esc) begin
          iter_nx  = n_inc;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          zr_nx = zr_new;
          zi_nx = zi_new;
          n_nx  = n_inc;
        end
      end
      default: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state     <= IDLE;
      done      <= 1'b1;
      iteration <= '0;
      n         <= '0;
      zr        <= '0;
      zi        <= '0;
      cr        <= '0;
      ci        <= '0;
    end else begin
      state     <= state_nx;
      done      <= done_nx;
      iteration <= iter_nx;
      n         <= n_nx;
      zr        <= zr_nx;
      zi        <= zi_nx;
      cr        <= cr_nx;
      ci        <= ci_nx;
    end
  end

endmodule

// File: tb/tb_point_generator.sv
// tb_point_generator: directed and random pixels against
// an arithmetic escape-time model.
module tb_point_generator;

  localparam int F = 29;
  localparam longint ONE = 64'sd1 <<< F;

  logic               CLK = 1'b0;
  logic               SYS_RESET_N;
  logic               start;
  logic signed [32:0] re_scale, im_scale;
  logic signed [32:0] re_start, im_start;
  logic [11:0]        x, y;
  logic               done;
  logic [31:0]        iteration;

  int total = 0;
  int bad   = 0;
  int last  = 0;

  always #5 CLK = ~CLK;

  point_generator dut (
    .CLK         (CLK),
    .SYS_RESET_N (SYS_RESET_N),
    .start       (start),
    .re_scale    (re_scale),
    .im_scale    (im_scale),
    .x           (x),
    .y           (y),
    .re_start    (re_start),
    .im_start    (im_start),
    .done        (done),
    .iteration   (iteration)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [127:0] map_c(
      input longint st, input longint sc, input int p);
    logic signed [127:0] t;
    logic signed [32:0]  c33;
    t   = 128'(p) * 128'(sc);
    t   = t >>> F;
    c33 = 33'(t) + 33'(st);
    return 128'(c33);
  endfunction

  function automatic int model(input longint rst, input longint ist,
                               input longint rsc, input longint isc,
                               input int px, input int py);
    logic signed [127:0] cr, ci, zr, zi, nr, ni, four;
    four = 128'sd4 <<< (2 * F);
    cr = map_c(rst, rsc, px);
    ci = map_c(ist, isc, py);
    zr = 0;
    zi = 0;
    for (int n = 1; n <= 255; n++) begin
      nr = ((zr * zr - zi * zi) >>> F) + cr;
      ni = ((2 * zr * zi) >>> F) + ci;
      if ((nr * nr + ni * ni > four) || n == 255) return n;
      zr = nr;
      zi = ni;
    end
    return 255;
  endfunction

  task automatic go(input string tag, input longint rst,
                    input longint ist, input longint rsc,
                    input longint isc, input int px, input int py,
                    input int busy_at);
    int exp, edges;
    exp = model(rst, ist, rsc, isc, px, py);
    re_start = 33'(rst);
    im_start = 33'(ist);
    re_scale = 33'(rsc);
    im_scale = 33'(isc);
    x = 12'(px);
    y = 12'(py);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, done, 0);
    chk({tag, "_hold"}, iteration, last);
    edges = 0;
    while (!done && edges < 400) begin
      start = (edges + 1 == busy_at);
      @(posedge CLK);
      #1;
      edges++;
      start = 1'b0;
    end
    chk({tag, "_lat"}, edges, exp + 1);
    chk({tag, "_iter"}, iteration, exp);
    last = exp;
  endtask

  initial begin
    longint rs, is, rsc, isc;
    SYS_RESET_N = 1'b0;
    start = 1'b0;
    re_scale = '0;
    im_scale = '0;
    re_start = '0;
    im_start = '0;
    x = '0;
    y = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_done", done, 1);
    chk("rst_iter", iteration, 0);
    @(negedge CLK);
    SYS_RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_done", done, 1);

    go("edge", -2 * ONE, -ONE, ONE / 4, ONE / 4, 0, 0, -1);
    go("inset", -2 * ONE, 0, ONE / 4, ONE / 4, 8, 0, -1);
    go("c1busy", ONE, 0, 0, 0, 0, 0, 2);
    repeat (3) @(posedge CLK);
    #1;
    chk("busy_ignored", done, 1);
    go("c2", 2 * ONE, 0, 0, 0, 0, 0, -1);
    go("b2b_c3", 3 * ONE, 0, 0, 0, 0, 0, -1);
    go("cm2", -2 * ONE, 0, 0, 0, 0, 0, -1);

    for (int k = 0; k < 16; k++) begin
      rs  = longint'($urandom_range(0, 32'd1610612736)) - 2 * ONE;
      is  = longint'($urandom_range(0, 32'd1073741824)) - 3 * ONE / 2;
      rsc = longint'($urandom_range(0, 32'd131072));
      isc = longint'($urandom_range(0, 32'd131072));
      go("rnd", rs, is, rsc, isc, int'($urandom_range(0, 4095)),
         int'($urandom_range(0, 4095)), -1);
    end

    re_start = '0;
    im_start = '0;
    x = '0;
    y = '0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #3;
    SYS_RESET_N = 1'b0;
    #1;
    chk("abort_done", done, 1);
    chk("abort_iter", iteration, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    SYS_RESET_N = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("post_done", done, 1);
    chk("post_iter", iteration, 0);
    last = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
